// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: state encoding and output-buffer depth shared by ram_burst_reader and its FIFO.
package ram_reader_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: command, RAM read port and beat-stream signals of ram_burst_reader.
// err exists only when RAM_READER_BOUNDS_EN is defined.
interface ram_burst_reader_if #(
    parameter int BITS = 8,
    parameter int N = 1024
);
    localparam int AW = $clog2(N);
    logic cmd_valid;
    logic cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0] cmd_len;
    logic [AW-1:0] read_addr;
    logic [BITS-1:0] read_data;
    logic out_valid;
    logic out_ready;
    logic [BITS-1:0] out_data;
    logic out_last;
    logic done;
    logic busy;
`ifdef RAM_READER_BOUNDS_EN
    logic err;
`endif
    modport master (
`ifdef RAM_READER_BOUNDS_EN
        input err,
`endif
        output cmd_valid, cmd_addr, cmd_len, read_data, out_ready,
        input cmd_ready, read_addr, out_valid, out_data, out_last, done, busy
    );
    modport slave (
`ifdef RAM_READER_BOUNDS_EN
        output err,
`endif
        input cmd_valid, cmd_addr, cmd_len, read_data, out_ready,
        output cmd_ready, read_addr, out_valid, out_data, out_last, done, busy
    );
endinterface

// File: rtl/ram_reader_fifo2.sv
// ram_reader_fifo2: 2-entry {last, data} FIFO with valid/ready on both sides.
module ram_reader_fifo2 import ram_reader_pkg::*; #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_last
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [BITS:0] mem [FIFO_DEPTH];
    logic wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic wr, rd;
    assign in_ready = count != CW'(FIFO_DEPTH);
    assign out_valid = count != '0;
    assign {out_last, out_data} = mem[rd_ptr];
    assign wr = in_valid && in_ready;
    assign rd = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= '0;
        end else begin
            if (wr) mem[wr_ptr] <= {in_last, in_data};
            wr_ptr <= wr_ptr ^ wr;
            rd_ptr <= rd_ptr ^ rd;
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams cmd_len words from a 1-cycle-latency synchronous RAM starting at cmd_addr.
// Define RAM_READER_BOUNDS_EN to reject bursts running past N (err pulse) instead of wrapping.
module ram_burst_reader import ram_reader_pkg::*; #(
    parameter int BITS = 8,
    parameter int N = 1024
) (
    input logic clk,
    input logic rst_n,
    ram_burst_reader_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int LW = AW + 1;
    localparam int SW = AW + 2;
    state_t state, state_n;
    logic [AW-1:0] addr;
    logic [AW:0] remaining;
    logic inflight, inflight_last, done_q;
    logic accept, start, oob, issue, last_issue, pop, fifo_in_ready;
    logic [2:0] occ;
    assign bus.cmd_ready = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.read_addr = addr;
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign start = accept && bus.cmd_len != '0 && !oob;
    assign pop = bus.out_valid && bus.out_ready;
    // a beat leaving this cycle frees its slot for the read issued now
    assign occ = (!fifo_in_ready ? 3'd2 : 3'(bus.out_valid)) + 3'(inflight) - 3'(pop);
    assign issue = state == READ && occ < 3'(FIFO_DEPTH);
    assign last_issue = issue && remaining == LW'(1);
    assign bus.done = done_q || (state == DRAIN && pop && bus.out_last);
`ifdef RAM_READER_BOUNDS_EN
    logic err_q;
    assign oob = SW'(bus.cmd_addr) + SW'(bus.cmd_len) > SW'(N);
    assign bus.err = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else err_q <= accept && oob;
    end
`else
    assign oob = 1'b0;
`endif
    always_comb begin
        state_n = state;
        if (state == IDLE && start) state_n = READ;
        else if (state == READ && last_issue) state_n = DRAIN;
        else if (state == DRAIN && pop && bus.out_last) state_n = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            remaining <= '0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                addr <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (issue) begin
                addr <= addr == AW'(N - 1) ? '0 : addr + AW'(1);
                remaining <= remaining - LW'(1);
            end
            inflight <= issue;
            inflight_last <= last_issue;
            done_q <= accept && (bus.cmd_len == '0 || oob);
        end
    end
    ram_reader_fifo2 #(.BITS(BITS)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight),
        .in_ready  (fifo_in_ready),
        .in_data   (bus.read_data),
        .in_last   (inflight_last),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last)
    );
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed bursts against a RAM[i] = i model with a beat scoreboard.
module tb_ram_burst_reader;
    localparam int BITS = 8;
    localparam int N = 16;
`ifdef RAM_READER_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic tog_en = 1'b0;
    logic phase = 1'b0;
    logic [BITS-1:0] mem [N];
    logic [8:0] q [$];
    logic [8:0] mexp;
    logic stall = 1'b0;
    logic [BITS-1:0] hold_data;
    logic hold_last;
    int vectors = 0;
    int miscompares = 0;
    int beats = 0;

    ram_burst_reader_if #(.BITS(BITS), .N(N)) bus ();
    ram_burst_reader #(.BITS(BITS), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) bus.read_data <= mem[bus.read_addr];
    always @(posedge clk) #1 phase <= ~phase;
    assign bus.out_ready = tog_en ? phase : rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(hold_data));
                check("hold_last", 32'(bus.out_last), 32'(hold_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                mexp = q.size() != 0 ? q.pop_front() : 9'bx;
                check("beat", 32'({bus.out_last, bus.out_data}), 32'(mexp));
                check("done_on_last", 32'(bus.done), 32'(mexp[8]));
                beats++;
            end
            stall <= bus.out_valid && !bus.out_ready;
            hold_data <= bus.out_data;
            hold_last <= bus.out_last;
        end else stall <= 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int l);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = 4'(a);
        bus.cmd_len = 5'(l);
        while (!bus.cmd_ready && n < 200) begin
            step();
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        if (l > 0 && !(BOUNDS && a + l > N))
            for (int k = 0; k < l; k++) q.push_back({k == l - 1, 8'((a + k) % N)});
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || bus.busy) && n < 200) begin
            step();
            n++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        check("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_read_addr", 32'(bus.read_addr), 32'd0);
    endtask

    initial begin
        int b0;
        int n;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // basic burst and first-beat latency
        send(5, 4);
        step();
        check("lat_early", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_data", 32'(bus.out_data), 32'd5);
        wait_drain();

        // backpressure
        tog_en = 1'b1;
        send(3, 6);
        wait_drain();
        tog_en = 1'b0;

        // zero length
        send(7, 0);
        check("zero_done", 32'(bus.done), 32'd1);
        check("zero_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("zero_done_end", 32'(bus.done), 32'd0);
        check("zero_valid_end", 32'(bus.out_valid), 32'd0);
        check("zero_busy", 32'(bus.busy), 32'd0);

        // wrap past N-1
        send(14, 4);
`ifdef RAM_READER_BOUNDS_EN
        check("oob_done", 32'(bus.done), 32'd1);
        check("oob_err", 32'(bus.err), 32'd1);
        check("oob_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("oob_err_end", 32'(bus.err), 32'd0);
`endif
        wait_drain();

        // reset mid-burst
        b0 = beats;
        send(2, 8);
        n = 0;
        while (beats < b0 + 2 && n < 100) begin
            step();
            n++;
        end
        check("mid_beats", 32'(beats - b0), 32'd2);
        rst_n = 1'b0;
        #1;
        q.delete();
        check_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        step();
        send(0, 3);
        wait_drain();

        // back-to-back commands
        send(1, 3);
        check("b2b_blocked", 32'(bus.cmd_ready), 32'd0);
        send(9, 2);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter BITS, default 8, RAM data width.
REQ-002 SHALL have parameter N, default 1024, RAM depth; AW = $clog2(N).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  burst command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_addr  input  AW  burst start address.
REQ-008 SHALL have port cmd_len  input  AW+1  beat count, 0..N.
REQ-009 SHALL have port read_addr  output  AW  address to the synchronous RAM, which returns data exactly 1 cycle later.
REQ-010 SHALL have port read_data  input  BITS  RAM read data.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
REQ-013 SHALL have port out_data  output  BITS  burst beat.
REQ-014 SHALL have port out_last  output  1  final beat of the burst.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN; cmd_ready = (state == IDLE).
REQ-018 IDLE: on accept with cmd_len > 0 SHALL load addr = cmd_addr, remaining = cmd_len, then go to READ.
REQ-019 IDLE: on accept with cmd_len == 0 SHALL pulse done on the next cycle, emit no beats, and stay in IDLE.
REQ-020 READ: SHALL issue a read only when fifo_count + inflight < 2, then increment addr and decrement remaining.
REQ-021 Issued data SHALL be written into the 2-entry output FIFO exactly 1 cycle after issue, tagged last when remaining was 1 at issue.
REQ-022 READ -> DRAIN SHALL occur in the cycle the final read is issued.
REQ-023 DRAIN -> IDLE SHALL occur on the handshake of the last beat, with done pulsing that same cycle.
REQ-024 With continuous out_ready, throughput SHALL be 1 beat per cycle and first-beat latency 2 cycles from command accept.
REQ-025 With out_ready held low, out_valid, out_data and out_last SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-026 Address arithmetic SHALL be modulo N (N-1 wraps to 0) unless REQ-031 applies.
REQ-027 read_addr SHALL be driven from the addr register at all times; reads are idempotent, so non-issue cycles are harmless.

Reset
REQ-028 While rst_n is low, the block SHALL force state = IDLE, FIFO empty, inflight = 0, addr = 0, remaining = 0, out_valid = 0, out_last = 0, done = 0, busy = 0, cmd_ready = 1, and out_data = 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after release, the first accepted command SHALL start cleanly.

Configuration
REQ-030 Macro RAM_READER_BOUNDS_EN SHALL select the bounds-check behaviour.
REQ-031 With RAM_READER_BOUNDS_EN defined: a command with cmd_addr + cmd_len > N SHALL be accepted, emit no beats, pulse done and output err (1 bit, registered) for one cycle, and remain in IDLE.
REQ-032 Without RAM_READER_BOUNDS_EN: no err port; bursts SHALL wrap per REQ-026.

Structure
REQ-033 Package ram_reader_pkg SHALL hold the state enum (IDLE/READ/DRAIN) and the FIFO depth constant (2).
REQ-034 The output buffer SHALL be sub-module ram_reader_fifo2, a 2-entry {last, data} FIFO with valid/ready ports.

Verification
REQ-035 Basic burst: RAM[i] = i, cmd addr 5, len 4, out_ready = 1 -> beats 5,6,7,8; last on 8; done with the last beat; first beat 2 cycles after accept.
REQ-036 Backpressure: len 6, out_ready toggling 1010... -> all 6 beats delivered in order, no duplicates, outputs stable while stalled.
REQ-037 Wrap: N = 16, addr 14, len 4 -> beats from addresses 14,15,0,1 (macro undefined); with macro -> err and done pulse, zero beats.
REQ-038 Zero length: len 0 -> done 1 cycle after accept, out_valid never asserted.
REQ-039 Reset mid-burst: rst_n low after beat 2 of 8 -> all outputs at reset values; a new burst at addr 0, len 3 -> beats 0,1,2.
REQ-040 Back-to-back: second command presented during the first burst -> cmd_ready stays low until IDLE; the second burst follows with correct data.
